// File: rtl/audio_sample_fifo.sv
// ============================================================================
// audio_sample_fifo
// ----------------------------------------------------------------------------
// First-word-fall-through buffer for 48-bit stereo audio samples.
// The left channel is in [47:24] and the right channel is in [23:0].
// The buffer sits between the sample writer and the I2S serializer.
// The head sample is always visible on `data`, and the serializer pops it
// with a one-cycle `data_rd` pulse per frame.
//
// Underrun and overflow are handled deterministically:
//   - A pop while empty pops nothing and bumps `underrun_count`.
//   - A write while full (with no pop that cycle) is dropped and bumps
//     `overflow_count`.
// Both counters saturate at 16'hFFFF.
//
// Optional feature macro: AUDIO_FIFO_HOLD_LAST_EN
//   defined   : when empty, `data` repeats the last successfully popped
//               sample (held in a register cleared only by reset).
//   undefined : when empty, `data` is all zeros (silence), and no hold
//               register is built.
//
// Parameters:
//   DATA_WIDTH    - sample width (48)
//   ADDR_WIDTH    - log2 of depth; DEPTH = 2**ADDR_WIDTH (16)
//   LOW_WATERMARK - low_water asserts while level <= this value (4)
//
// Ports:
//   clk            in   single clock for the whole block
//   reset          in   asynchronous, active-high reset
//   data_in        in   sample to write
//   data_wr        in   write strobe, one sample per cycle while high
//   full           out  level == DEPTH
//   data           out  head sample, or the underrun fill value when empty
//   data_rd        in   pop strobe from the I2S side
//   empty          out  level == 0
//   level          out  current occupancy, 0..DEPTH
//   low_water      out  level <= LOW_WATERMARK
//   flush          in   synchronous discard of all contents
//   clear_stats    in   synchronous clear of both counters
//   underrun_count out  saturating count of pops taken while empty
//   overflow_count out  saturating count of writes dropped while full
// ============================================================================
module audio_sample_fifo #(
    parameter int DATA_WIDTH    = 48,
    parameter int ADDR_WIDTH    = 4,
    parameter int LOW_WATERMARK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_wr,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  data_rd,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  low_water,
    input  logic                  flush,
    input  logic                  clear_stats,
    output logic [15:0]           underrun_count,
    output logic [15:0]           overflow_count
);

    localparam int                DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LOW_WM_LVL = (ADDR_WIDTH + 1)'(LOW_WATERMARK);
    localparam logic [15:0]       CNT_MAX    = 16'hFFFF;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic [ADDR_WIDTH:0]   level_next;
    logic [15:0]           underrun_q;
    logic [15:0]           overflow_q;

    logic                  is_empty;
    logic                  is_full;
    logic                  do_pop;
    logic                  do_push;
    logic                  underrun_hit;
    logic                  overflow_hit;
    logic [DATA_WIDTH-1:0] head_sample;
    logic [DATA_WIDTH-1:0] fill_value;

    // All status flags come straight from the registered level counter.
    // They therefore change exactly one cycle after the edge that caused
    // the change, and never glitch on the incoming strobes.
    assign is_empty  = (level_q == '0);
    assign is_full   = (level_q == DEPTH_LVL);
    assign empty     = is_empty;
    assign full      = is_full;
    assign level     = level_q;
    assign low_water = (level_q <= LOW_WM_LVL);

    assign underrun_count = underrun_q;
    assign overflow_count = overflow_q;

    // Decide what actually happens to the storage this cycle.
    //
    // Flush overrides everything: the write is discarded and neither
    // strobe is counted.
    //
    // A pop is only real when something is stored. A write is accepted
    // when there is room, or when a real pop in the same cycle frees a
    // slot. A full FIFO is never empty, so a read while full always pops.
    //
    // There is no bypass path. A write and read to an empty FIFO stores
    // the sample and counts the read as an underrun.
    always_comb begin
        do_pop       = 1'b0;
        do_push      = 1'b0;
        underrun_hit = 1'b0;
        overflow_hit = 1'b0;
        if (!flush) begin
            do_pop       = data_rd && !is_empty;
            do_push      = data_wr && (!is_full || do_pop);
            underrun_hit = data_rd && is_empty;
            overflow_hit = data_wr && is_full && !do_pop;
        end
    end

    // Next occupancy.
    // Flush empties the FIFO. Otherwise, a push and a pop in the same
    // cycle cancel, and a lone push or pop moves the level by one.
    always_comb begin
        level_next = level_q;
        if (flush) begin
            level_next = '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   level_next = level_q + 1'b1;
                2'b01:   level_next = level_q - 1'b1;
                default: level_next = level_q;
            endcase
        end
    end

    // Pointer and level registers.
    // The pointers wrap naturally modulo DEPTH because they are exactly
    // ADDR_WIDTH bits wide. Flush returns both pointers to zero so the
    // next write lands in slot 0, just as it would after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Sample storage.
    // The storage array is deliberately left without a reset. Its contents
    // are only ever observed through `data` while level is non-zero, and
    // reset forces level to zero. Stale contents are therefore invisible
    // after reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Error counters.
    // clear_stats wins over an increment in the same cycle. Each counter
    // sticks at all-ones rather than wrapping, so software can still tell
    // that a large number of events happened.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_q <= '0;
            overflow_q <= '0;
        end else if (clear_stats) begin
            underrun_q <= '0;
            overflow_q <= '0;
        end else begin
            if (underrun_hit && (underrun_q != CNT_MAX)) begin
                underrun_q <= underrun_q + 16'd1;
            end
            if (overflow_hit && (overflow_q != CNT_MAX)) begin
                overflow_q <= overflow_q + 16'd1;
            end
        end
    end

    assign head_sample = mem[rd_ptr];

`ifdef AUDIO_FIFO_HOLD_LAST_EN
    logic [DATA_WIDTH-1:0] hold_q;

    // Remember the last sample handed to the serializer, so an underrun
    // repeats the previous frame instead of dropping to silence.
    // Flush intentionally leaves this register alone; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else if (do_pop) begin
            hold_q <= head_sample;
        end
    end

    assign fill_value = hold_q;
`else
    // Without the hold feature, an underrun simply outputs silence.
    assign fill_value = '0;
`endif

    // First-word-fall-through output.
    // The head slot is visible as soon as the level is non-zero. The fill
    // value takes over whenever the FIFO is empty.
    assign data = is_empty ? fill_value : head_sample;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// ============================================================================
// tb_audio_sample_fifo
// ----------------------------------------------------------------------------
// Directed self-checking bench for audio_sample_fifo.
//
// Inputs are driven 1 ns after each rising edge, and outputs are sampled
// 1 ns after the following rising edge, so nothing races the clock.
//
// Expected values are hand-computed. The fill value seen while empty
// depends on whether AUDIO_FIFO_HOLD_LAST_EN is defined, and the bench
// selects the matching expectation.
// ============================================================================
module tb_audio_sample_fifo;

    localparam int DW = 48;
    localparam int AW = 4;

`ifdef AUDIO_FIFO_HOLD_LAST_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          data_wr;
    logic          full;
    logic [DW-1:0] data;
    logic          data_rd;
    logic          empty;
    logic [AW:0]   level;
    logic          low_water;
    logic          flush;
    logic          clear_stats;
    logic [15:0]   underrun_count;
    logic [15:0]   overflow_count;

    int checks = 0;
    int errors = 0;

    audio_sample_fifo #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .LOW_WATERMARK(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_wr       (data_wr),
        .full          (full),
        .data          (data),
        .data_rd       (data_rd),
        .empty         (empty),
        .level         (level),
        .low_water     (low_water),
        .flush         (flush),
        .clear_stats   (clear_stats),
        .underrun_count(underrun_count),
        .overflow_count(overflow_count)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns what `data` should show while empty, given the last sample
    // that was successfully popped.
    function automatic logic [DW-1:0] fillOf(input logic [DW-1:0] last_popped);
        return HOLD_EN ? last_popped : '0;
    endfunction

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of strobes, wait for the edge, then release strobes.
    // The caller checks the outputs immediately afterwards, 1 ns past the edge.
    task automatic applyStimulus(input logic wr, input logic [DW-1:0] din,
                                 input logic rd, input logic fl, input logic cs);
        data_wr     = wr;
        data_in     = din;
        data_rd     = rd;
        flush       = fl;
        clear_stats = cs;
        @(posedge clk);
        #1;
        data_wr     = 1'b0;
        data_rd     = 1'b0;
        flush       = 1'b0;
        clear_stats = 1'b0;
    endtask

    // Linear directed sequence covering the main paths and the corner cases.
    initial begin
        reset       = 1'b1;
        data_in     = '0;
        data_wr     = 1'b0;
        data_rd     = 1'b0;
        flush       = 1'b0;
        clear_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ---------------- reset state ----------------
        $display("[TB] reset values");
        checkOutput("rst_data",      data, 0);
        checkOutput("rst_empty",     empty, 1);
        checkOutput("rst_full",      full, 0);
        checkOutput("rst_level",     level, 0);
        checkOutput("rst_low_water", low_water, 1);
        checkOutput("rst_underrun",  underrun_count, 0);
        checkOutput("rst_overflow",  overflow_count, 0);

        // ---------------- three writes, three pops ----------------
        $display("[TB] basic write/read order");
        applyStimulus(1, 48'h000001_FFFFFF, 0, 0, 0);
        checkOutput("w1_level", level, 1);
        checkOutput("w1_empty", empty, 0);
        checkOutput("w1_data",  data, 48'h000001_FFFFFF);
        applyStimulus(1, 48'h000002_FFFFFE, 0, 0, 0);
        applyStimulus(1, 48'h000003_FFFFFD, 0, 0, 0);
        checkOutput("w3_level", level, 3);
        checkOutput("w3_data",  data, 48'h000001_FFFFFF);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("r1_data",  data, 48'h000002_FFFFFE);
        checkOutput("r1_level", level, 2);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("r2_data",  data, 48'h000003_FFFFFD);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("r3_empty", empty, 1);
        checkOutput("r3_level", level, 0);
        checkOutput("r3_data",  data, fillOf(48'h000003_FFFFFD));
        checkOutput("r3_underrun", underrun_count, 0);

        // ---------------- underrun ----------------
        $display("[TB] underrun fill value");
        applyStimulus(1, 48'hABCDEF_123456, 0, 0, 0);
        checkOutput("u_w_data", data, 48'hABCDEF_123456);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("u_pop_empty", empty, 1);
        applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("u_underrun", underrun_count, 2);
        checkOutput("u_data",     data, fillOf(48'hABCDEF_123456));
        checkOutput("u_level",    level, 0);

        // ---------------- fill past full ----------------
        $display("[TB] overflow");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 48'h100 + 48'(i), 0, 0, 0);
            checkOutput("fill_level", level, (i < 16) ? i + 1 : 16);
            checkOutput("fill_full",  full, (i >= 15) ? 1 : 0);
        end
        checkOutput("ovf_count",     overflow_count, 1);
        checkOutput("ovf_data",      data, 48'h100);
        checkOutput("ovf_low_water", low_water, 0);
        applyStimulus(1, 48'h200, 1, 0, 0);
        checkOutput("wr_rd_full_level", level, 16);
        checkOutput("wr_rd_full_ovf",   overflow_count, 1);
        checkOutput("wr_rd_full_data",  data, 48'h101);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, '0, 1, 0, 0);
            checkOutput("drain_level", level, 15 - i);
            checkOutput("drain_data", data,
                        (i < 14) ? 48'h102 + 48'(i) : (i == 14) ? 48'h200 : fillOf(48'h200));
        end
        checkOutput("drain_empty",    empty, 1);
        checkOutput("drain_underrun", underrun_count, 2);

        // ---------------- steady-state interleave with wrap ----------------
        $display("[TB] interleaved write/pop");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 48'h300 + 48'(i), 0, 0, 0);
        end
        checkOutput("il_start_level", level, 5);
        checkOutput("il_start_lw",    low_water, 0);
        checkOutput("il_start_data",  data, 48'h300);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 48'h305 + 48'(i), 1, 0, 0);
            checkOutput("il_level", level, 5);
            checkOutput("il_data",  data, 48'h301 + 48'(i));
            checkOutput("il_lw",    low_water, 0);
        end

        // ---------------- flush and clear_stats ----------------
        $display("[TB] flush and clear_stats");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 48'h32D + 48'(i), 0, 0, 0);
        end
        checkOutput("fl_pre_level", level, 10);
        applyStimulus(1, 48'h999, 1, 1, 0);
        checkOutput("fl_level",    level, 0);
        checkOutput("fl_empty",    empty, 1);
        checkOutput("fl_full",     full, 0);
        checkOutput("fl_underrun", underrun_count, 2);
        checkOutput("fl_overflow", overflow_count, 1);
        checkOutput("fl_data",     data, fillOf(48'h327));
        applyStimulus(0, '0, 1, 0, 1);
        checkOutput("cs_underrun", underrun_count, 0);
        checkOutput("cs_overflow", overflow_count, 0);

        // ---------------- asynchronous reset mid-burst ----------------
        $display("[TB] async reset");
        applyStimulus(0, '0, 1, 0, 0);
        checkOutput("ar_pre_underrun", underrun_count, 1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 48'h400 + 48'(i), 0, 0, 0);
        end
        checkOutput("ar_pre_level", level, 7);
        checkOutput("ar_pre_data",  data, 48'h400);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("ar_level",     level, 0);
        checkOutput("ar_empty",     empty, 1);
        checkOutput("ar_full",      full, 0);
        checkOutput("ar_low_water", low_water, 1);
        checkOutput("ar_data",      data, 0);
        checkOutput("ar_underrun",  underrun_count, 0);
        checkOutput("ar_overflow",  overflow_count, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Synchronous first-word-fall-through buffer for 48-bit stereo audio samples (24-bit left in [47:24], 24-bit right in [23:0]) between the sample writer and `i2s_controller`. It accepts `data_in`/`data_wr` from the writer and presents the head sample on `data` for the I2S serializer, which pops it with a one-cycle `data_rd` pulse per frame. It handles underrun and overflow deterministically and exposes level and error counters for the register unit.

## Interface
- `DATA_WIDTH`, 48: sample width.
- `ADDR_WIDTH`, 4: log2 of depth; DEPTH = 2**ADDR_WIDTH = 16.
- `LOW_WATERMARK`, 4: `low_water` asserts when level ≤ this value.

- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high.
- `data_in` in DATA_WIDTH: sample to write.
- `data_wr` in 1: write strobe, one sample per cycle high.
- `full` out 1: level == DEPTH.
- `data` out DATA_WIDTH: head sample, or underrun fill value when empty.
- `data_rd` in 1: pop strobe from the I2S side.
- `empty` out 1: level == 0.
- `level` out ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `low_water` out 1: level ≤ LOW_WATERMARK.
- `flush` in 1: synchronous discard of all contents.
- `clear_stats` in 1: synchronous clear of both counters.
- `underrun_count` out 16: saturating count of `data_rd` pulses taken while empty.
- `overflow_count` out 16: saturating count of writes dropped while full.

## Operation
- Storage is a DEPTH-entry flop array, with write and read pointers of ADDR_WIDTH bits that wrap modulo DEPTH. `level` is a separate ADDR_WIDTH+1 counter.
- Write: `data_wr` with `full`=0 stores `data_in` at the write pointer, then increments the pointer.
- Write while full and no pop: the sample is dropped, pointers are unchanged, and `overflow_count` increments.
- Read: `data_rd` with `empty`=0 advances the read pointer, and `level` decrements.
- Read while empty: nothing is popped, and `underrun_count` increments.
- `data` rules:
  - When `empty`=0, `data` is mem[rd_ptr].
  - When `empty`=1, `data` is the underrun fill value (see Configuration).
- Simultaneous write and read, not empty: both happen, and `level` is unchanged.
- Simultaneous write and read while full: both happen. The pop frees the slot, so the write is not counted as an overflow.
- Simultaneous write and read while empty: there is no bypass. The read is an underrun, the write is stored, and `level` becomes 1.
- `flush` has priority over `data_wr` and `data_rd` in the same cycle:
  - Pointers and `level` go to 0.
  - The write is discarded and not counted.
  - The read is not counted.
  - Counters are otherwise unaffected.
- `clear_stats` zeroes both counters. It has priority over an increment in the same cycle.
- Counters saturate at 16'hFFFF.
- There is no state machine beyond the pointer/level logic. The block is state = {wr_ptr, rd_ptr, level, hold register, counters}.

## Timing
- Reset values: `data`=0, `empty`=1, `full`=0, `level`=0, `low_water`=1, both counters 0, pointers 0, hold register 0.
- Write-to-output latency is 1 cycle. After a write to an empty FIFO at edge N, `empty`=0 and `data`=written sample are valid after edge N, so the I2S side may pop from edge N+1.
- Pop-to-next-sample latency is 1 cycle. After `data_rd` at edge N, the next entry, or the fill value if the FIFO went empty, is on `data` after edge N.
- All status outputs (`full`, `empty`, `level`, `low_water`) are registered or derived only from registered state, and update the cycle after the causing edge.
- `flush` and `clear_stats` take effect at the edge they are sampled high.
- Reset asserted mid-operation returns everything to reset values immediately. Contents are not preserved.

## Configuration
- `AUDIO_FIFO_HOLD_LAST_EN` defined:
  - Fill value when empty is the last sample successfully popped, held in a DATA_WIDTH register updated on every successful pop. It is cleared by reset but not by `flush`.
  - Underrun therefore repeats the previous frame.
- Not defined:
  - Fill value when empty is all zeros, so underrun produces silence.
  - The hold register is not built.

## Test plan
- After reset, write 3 samples 48'h000001_FFFFFF, 48'h000002_FFFFFE, 48'h000003_FFFFFD on consecutive cycles → `level`=3 and `data`=48'h000001_FFFFFF one cycle after the first write. Three pops return the samples in order, then `empty`=1.
- Write 17 samples with no reads → `full`=1 at `level`=16, the 17th is dropped, and `overflow_count`=1. Write and read together while full → `level` stays 16 and `overflow_count` stays 1.
- Pop 2 times while empty, after the last popped sample 48'hABCDEF_123456:
  - Without the macro: `data`=0 and `underrun_count`=2.
  - With `AUDIO_FIFO_HOLD_LAST_EN`: `data`=48'hABCDEF_123456 and `underrun_count`=2.
- Run 40 interleaved write/pop pairs with `level` starting at 5 → pointers wrap twice, data order is preserved, `level`=5 throughout, and `low_water`=0.
- Fill to 10, then assert `flush` with `data_wr`=1 and `data_rd`=1 in the same cycle → `level`=0, `empty`=1, and counters are unchanged. Assert `clear_stats` → both counters are 0.
- Assert `reset` asynchronously mid-burst at `level`=7 → all outputs take their reset values without waiting for a clock edge.
